// File: rtl/branch_sequencer_pkg.sv
// Shared types for the branch sequencer: ALU op encoding, flag bit positions,
// RV32I branch funct3 codes and the sequencer state enum.
`ifndef FlagSize
`define FlagSize 4
`endif

package branch_sequencer_pkg;

  typedef enum logic [3:0] {
    AddOp  = 4'd0,
    SubOp  = 4'd1,
    AndOp  = 4'd2,
    OrOp   = 4'd3,
    XorOp  = 4'd4,
    SllOp  = 4'd5,
    SrlOp  = 4'd6,
    SraOp  = 4'd7,
    SltOp  = 4'd8,
    SltuOp = 4'd9
  } ALU_Ops;

  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    TARGET  = 2'd2,
    DONE    = 2'd3
  } BranchSeqState;

endpackage

// File: rtl/branch_sequencer_cond.sv
// Combinational branch condition evaluation from the ALU's SubOp flags.
// C is the unsigned borrow of rs1 - rs2.
module branch_cond
  import branch_sequencer_pkg::*;
(
  input  logic [`FlagSize-1:0] flags_i,
  input  logic [2:0]           funct3_i,
  output logic                 taken_o,
  output logic                 illegal_o
);

  logic flag_v, flag_n, flag_c, flag_z;

  assign flag_v = flags_i[FLAG_V];
  assign flag_n = flags_i[FLAG_N];
  assign flag_c = flags_i[FLAG_C];
  assign flag_z = flags_i[FLAG_Z];

  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = flag_z;
      F3_BNE:  taken_o = !flag_z;
      F3_BLT:  taken_o = flag_n ^ flag_v;
      F3_BGE:  taken_o = !(flag_n ^ flag_v);
      F3_BLTU: taken_o = flag_c;
      F3_BGEU: taken_o = !flag_c;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle RV32I conditional branch resolver driving a shared ALU:
// compare (SubOp), then target (AddOp), then a one-cycle done pulse.
// Optional BRANCH_SEQ_EARLY_OUT_EN skips the target step for not-taken branches.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [DATA_WIDTH-1:0] rs1_i,
  input  logic [DATA_WIDTH-1:0] rs2_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output ALU_Ops                alu_op_o,
  input  logic [DATA_WIDTH-1:0] alu_y_i,
  input  logic [`FlagSize-1:0]  alu_flags_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  taken_o,
  output logic [DATA_WIDTH-1:0] target_o,
  output logic                  illegal_o
);

  BranchSeqState         state_q, state_d;
  logic [2:0]            funct3_q;
  logic [DATA_WIDTH-1:0] rs1_q, rs2_q, pc_q, imm_q;
  logic [DATA_WIDTH-1:0] target_q;
  logic                  taken_q, illegal_q;
  logic                  accept;
  logic                  cond_taken, cond_illegal;

  assign accept = start_i && ((state_q == IDLE) || (state_q == DONE));

  branch_cond u_cond (
    .flags_i  (alu_flags_i),
    .funct3_i (funct3_q),
    .taken_o  (cond_taken),
    .illegal_o(cond_illegal)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = COMPARE;
      COMPARE: begin
`ifdef BRANCH_SEQ_EARLY_OUT_EN
        state_d = cond_taken ? TARGET : DONE;
`else
        state_d = TARGET;
`endif
      end
      TARGET:  state_d = DONE;
      DONE:    state_d = start_i ? COMPARE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand latches are frozen while busy; results are held until the next accepted start.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      target_q  <= '0;
    end else if (accept) begin
      funct3_q  <= funct3_i;
      rs1_q     <= rs1_i;
      rs2_q     <= rs2_i;
      pc_q      <= pc_i;
      imm_q     <= imm_i;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (state_q == COMPARE) begin
      taken_q   <= cond_taken;
      illegal_q <= cond_illegal;
`ifdef BRANCH_SEQ_EARLY_OUT_EN
      if (!cond_taken) target_q <= '0;
`endif
    end else if (state_q == TARGET) begin
      target_q <= alu_y_i;
    end
  end

  always_comb begin
    alu_a_o  = '0;
    alu_b_o  = '0;
    alu_op_o = AddOp;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    case (state_q)
      COMPARE: begin
        alu_a_o  = rs1_q;
        alu_b_o  = rs2_q;
        alu_op_o = SubOp;
        busy_o   = 1'b1;
      end
      TARGET: begin
        alu_a_o  = pc_q;
        alu_b_o  = imm_q;
        alu_op_o = AddOp;
        busy_o   = 1'b1;
      end
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign taken_o   = taken_q;
  assign illegal_o = illegal_q;
  assign target_o  = target_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a small stateless ALU model.
// Handles both default and BRANCH_SEQ_EARLY_OUT_EN builds.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] rs1_i, rs2_i, pc_i, imm_i;
  logic [31:0] alu_a_o, alu_b_o;
  ALU_Ops      alu_op_o;
  logic [31:0] alu_y_i;
  logic [3:0]  alu_flags_i;
  logic        busy_o, done_o, taken_o, illegal_o;
  logic [31:0] target_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk_i = ~clk_i;

  branch_sequencer #(.DATA_WIDTH(32)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .start_i    (start_i),
    .funct3_i   (funct3_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .pc_i       (pc_i),
    .imm_i      (imm_i),
    .alu_a_o    (alu_a_o),
    .alu_b_o    (alu_b_o),
    .alu_op_o   (alu_op_o),
    .alu_y_i    (alu_y_i),
    .alu_flags_i(alu_flags_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .taken_o    (taken_o),
    .target_o   (target_o),
    .illegal_o  (illegal_o)
  );

  // ALU: flags are V,N,C,Z; C is unsigned borrow for SubOp.
  always_comb begin
    alu_y_i     = 32'h0;
    alu_flags_i = 4'h0;
    if (alu_op_o == SubOp) begin
      alu_y_i        = alu_a_o - alu_b_o;
      alu_flags_i[1] = (alu_a_o < alu_b_o);
      alu_flags_i[3] = (alu_a_o[31] != alu_b_o[31]) && (alu_y_i[31] != alu_a_o[31]);
    end else begin
      alu_y_i = alu_a_o + alu_b_o;
    end
    alu_flags_i[2] = alu_y_i[31];
    alu_flags_i[0] = (alu_y_i == 32'h0);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_branch(input string name, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] pc, input logic [31:0] imm,
                            input logic exp_taken, input logic exp_illegal,
                            input logic [31:0] exp_target_full);
    int lat;
    int exp_lat;
    logic [31:0] exp_target;
    exp_lat    = 3;
    exp_target = exp_target_full;
`ifdef BRANCH_SEQ_EARLY_OUT_EN
    if (!exp_taken) begin
      exp_lat    = 2;
      exp_target = 32'h0;
    end
`endif
    funct3_i = f3; rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm;
    start_i  = 1'b1;
    step();
    start_i  = 1'b0;
    check({name, "_busy"}, 32'(busy_o), 32'd1);
    check({name, "_cmp_op"}, 32'(alu_op_o), 32'(SubOp));
    check({name, "_cmp_a"}, alu_a_o, a);
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done_o) begin
        lat = c;
        break;
      end
      step();
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_taken"}, 32'(taken_o), 32'(exp_taken));
    check({name, "_illegal"}, 32'(illegal_o), 32'(exp_illegal));
    check({name, "_target"}, target_o, exp_target);
    $display("txn %s f3=%b rs1=%h rs2=%h pc=%h imm=%h -> taken=%0d illegal=%0d target=%h lat=%0d",
             name, f3, a, b, pc, imm, taken_o, illegal_o, target_o, lat);
    step();
    check({name, "_done_pulse"}, 32'(done_o), 32'd0);
    check({name, "_held_taken"}, 32'(taken_o), 32'(exp_taken));
  endtask

  initial begin
    reset_ni = 1'b0; start_i = 1'b0; funct3_i = 3'b000;
    rs1_i = 32'h0; rs2_i = 32'h0; pc_i = 32'h0; imm_i = 32'h0;
    step();
    step();
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_taken", 32'(taken_o), 32'd0);
    check("rst_illegal", 32'(illegal_o), 32'd0);
    check("rst_target", target_o, 32'h0);
    check("rst_alu_a", alu_a_o, 32'h0);
    check("rst_alu_op", 32'(alu_op_o), 32'(AddOp));
    reset_ni = 1'b1;
    step();

    run_branch("beq",  3'b000, 32'h5,        32'h5, 32'h100, 32'h20, 1'b1, 1'b0, 32'h120);
    run_branch("blt",  3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8,  1'b1, 1'b0, 32'h208);
    run_branch("bltu", 3'b110, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8,  1'b0, 1'b0, 32'h208);
    run_branch("bge",  3'b101, 32'h80000000, 32'h1, 32'h300, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h2FC);
    run_branch("bgeu", 3'b111, 32'h80000000, 32'h1, 32'h300, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h2FC);
    run_branch("ill",  3'b011, 32'h7,        32'h7, 32'h400, 32'h10, 1'b0, 1'b1, 32'h410);
    run_branch("bnewr",3'b001, 32'h1,        32'h2, 32'hFFFFFFF0, 32'h20, 1'b1, 1'b0, 32'h10);

    // Back-to-back with start held high; inputs changed mid-flight must be ignored.
    funct3_i = 3'b001; rs1_i = 32'h1; rs2_i = 32'h2; pc_i = 32'h200; imm_i = 32'h4;
    start_i = 1'b1;
    step();
    rs1_i = 32'h5; rs2_i = 32'h5; pc_i = 32'h999;
    check("b2b_c1_done", 32'(done_o), 32'd0);
    step();
    rs1_i = 32'h10; rs2_i = 32'h20; pc_i = 32'hFFFFFFF0; imm_i = 32'h20;
    check("b2b_t1_done", 32'(done_o), 32'd0);
    step();
    check("b2b_d1_done", 32'(done_o), 32'd1);
    check("b2b_d1_taken", 32'(taken_o), 32'd1);
    check("b2b_d1_target", target_o, 32'h204);
    $display("txn b2b1 taken=%0d target=%h", taken_o, target_o);
    step();
    rs1_i = 32'h5; rs2_i = 32'h5; pc_i = 32'h999;
    check("b2b_c2_done", 32'(done_o), 32'd0);
    check("b2b_c2_busy", 32'(busy_o), 32'd1);
    step();
    start_i = 1'b0;
    check("b2b_t2_done", 32'(done_o), 32'd0);
    step();
    check("b2b_d2_done", 32'(done_o), 32'd1);
    check("b2b_d2_taken", 32'(taken_o), 32'd1);
    check("b2b_d2_target", target_o, 32'h10);
    $display("txn b2b2 taken=%0d target=%h", taken_o, target_o);
    step();
    check("b2b_idle_done", 32'(done_o), 32'd0);
    check("b2b_idle_busy", 32'(busy_o), 32'd0);

    // Reset while in TARGET aborts the branch.
    funct3_i = 3'b000; rs1_i = 32'h1; rs2_i = 32'h1; pc_i = 32'h40; imm_i = 32'h8;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    check("abort_in_target", 32'(alu_op_o), 32'(AddOp));
    check("abort_target_a", alu_a_o, 32'h40);
    reset_ni = 1'b0;
    step();
    reset_ni = 1'b1;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_taken", 32'(taken_o), 32'd0);
    check("abort_target", target_o, 32'h0);
    check("abort_alu_a", alu_a_o, 32'h0);
    $display("txn abort busy=%0d done=%0d taken=%0d target=%h", busy_o, done_o, taken_o, target_o);
    step();
    check("abort_no_done1", 32'(done_o), 32'd0);
    step();
    check("abort_no_done2", 32'(done_o), 32'd0);

    run_branch("after", 3'b000, 32'h9, 32'h9, 32'h1000, 32'h40, 1'b1, 1'b0, 32'h1040);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Multi-cycle initiator that drives the shared ALU's operand and op inputs, and consumes its result and VNCZ flags, to resolve RV32I conditional branches.
- Sits between the control matrix and the ALU datapath.
- Sequence: the control matrix pulses start; the block runs a SubOp compare, then an AddOp target computation (pc + imm), then reports taken/target/illegal with a done pulse.

Parameters:
- DATA_WIDTH, 32, operand, result and target width.

Ports:
- clk_i  input  1  clock.
- reset_ni  input  1  synchronous active-low reset.
- start_i  input  1  request; sampled only when not busy.
- funct3_i  input  3  branch funct3: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
- rs1_i  input  DATA_WIDTH  compare operand A.
- rs2_i  input  DATA_WIDTH  compare operand B.
- pc_i  input  DATA_WIDTH  branch instruction PC.
- imm_i  input  DATA_WIDTH  sign-extended B-immediate.
- alu_a_o  output  DATA_WIDTH  to ALU a_i.
- alu_b_o  output  DATA_WIDTH  to ALU b_i.
- alu_op_o  output  ALU_Ops  to ALU func_op_i.
- alu_y_i  input  DATA_WIDTH  from ALU y_o.
- alu_flags_i  input  `FlagSize  from ALU flags_o; bit 3=V, 2=N, 1=C, 0=Z.
- busy_o  output  1  high in COMPARE and TARGET.
- done_o  output  1  one-cycle completion pulse.
- taken_o  output  1  branch taken, held until next start.
- target_o  output  DATA_WIDTH  pc + imm, held until next start.
- illegal_o  output  1  funct3 was 010 or 011, held until next start.

Behaviour:
- Reset (reset_ni low at a clk_i edge):
  - State goes to IDLE.
  - busy_o, done_o, taken_o and illegal_o are 0; target_o is 0.
  - alu_a_o and alu_b_o are 0; alu_op_o is AddOp.
  - Reset during any state aborts the branch; done_o is not asserted.
- States: IDLE, COMPARE, TARGET, DONE.
- IDLE or DONE with start_i=1:
  - Latch funct3, rs1, rs2, pc and imm into internal registers.
  - Clear taken_o and illegal_o.
  - Go to COMPARE.
  - Without start_i, DONE returns to IDLE after one cycle.
- COMPARE:
  - Drive alu_a_o=rs1 (latched), alu_b_o=rs2 (latched), alu_op_o=SubOp.
  - On the edge, register taken and illegal from alu_flags_i and funct3.
  - Go to TARGET.
- Branch conditions (C = unsigned borrow):
  - BEQ: Z.
  - BNE: !Z.
  - BLT: N^V.
  - BGE: !(N^V).
  - BLTU: C.
  - BGEU: !C.
  - funct3 010 or 011: taken=0, illegal=1.
- TARGET:
  - Drive alu_a_o=pc (latched), alu_b_o=imm (latched), alu_op_o=AddOp.
  - On the edge, register target_o from alu_y_i.
  - Go to DONE.
  - Target arithmetic is modulo 2^DATA_WIDTH; wrap-around is not flagged.
- DONE:
  - done_o=1 for exactly this cycle.
  - taken_o, target_o and illegal_o are stable here and remain stable until the next accepted start.
- Latency: done_o is high in the 3rd cycle after the clock edge that accepted start (1 compare, 1 target, 1 done).
- Back-to-back: start_i while in DONE is accepted in that same cycle, giving a new done every 3 cycles.
- start_i in COMPARE or TARGET is ignored, not queued. The input registers are not updated while busy.
- ALU outputs are consumed combinationally in the same cycle the operands are driven; the ALU has no internal state.
- ALU drive in IDLE and DONE: alu_op_o=AddOp, alu_a_o=0, alu_b_o=0.

Optional Feature:
- Macro: BRANCH_SEQ_EARLY_OUT_EN.
- When defined:
  - If COMPARE resolves not-taken (including illegal), go straight from COMPARE to DONE and skip TARGET.
  - target_o is set to 0 in that case.
  - Not-taken latency is 2 cycles; taken latency stays at 3.
- When undefined: TARGET always runs and target_o = pc + imm regardless of taken.

Decomposition:
- Shared package (alongside the existing ALU_Ops enum and `FlagSize):
  - Flag bit index constants FLAG_V=3, FLAG_N=2, FLAG_C=1, FLAG_Z=0.
  - Branch funct3 localparams.
  - BranchSeqState enum.
- Sub-module branch_cond: combinational; flags + funct3 in, taken + illegal out. Instantiated once and registered on the COMPARE edge.

Test Plan:
- BEQ, rs1=rs2=0x00000005, pc=0x100, imm=0x20 -> done_o 3 cycles after start, taken_o=1, target_o=0x120, illegal_o=0.
- BLT, rs1=0xFFFFFFFF (-1), rs2=0x00000001 -> taken_o=1. BLTU with the same operands -> taken_o=0 (C=0).
- BGE, rs1=0x80000000, rs2=0x00000001 (signed overflow, V=1) -> taken_o=0. BGEU with the same operands -> taken_o=1.
- funct3=011 -> illegal_o=1, taken_o=0, done_o still pulses. With BRANCH_SEQ_EARLY_OUT_EN: done at cycle 2, target_o=0.
- start_i held high continuously with alternating BNE operands -> a done pulse every 3 cycles; starts during COMPARE/TARGET are ignored; pc=0xFFFFFFF0, imm=0x20 -> target_o=0x00000010.
- reset_ni low during TARGET -> next cycle IDLE, all outputs 0, no done_o; a new start then completes normally.
